// File: rtl/gpio_spi_master_if.sv
// Register-slot bus between the AXI-Lite register block and the SPI master:
// one write strobe, the shared write-data word, and the status readback word.
interface gpio_spi_master_if;
    logic        csrStrobe;
    logic [31:0] GPIO_OUT;
    logic [31:0] status;

    modport master (
        output csrStrobe,
        output GPIO_OUT,
        input  status
    );

    modport slave (
        input  csrStrobe,
        input  GPIO_OUT,
        output status
    );
endinterface

// File: rtl/gpio_spi_master.sv
// SPI mode-0, MSB-first, fixed-length master for configuring ADC/clock chips.
// Takes transfer commands from one register-slot write and reports status/rx data.
module gpio_spi_master #(
    parameter int CLK_DIV     = 4,
    parameter int SHIFT_WIDTH = 24,
    parameter int CS_COUNT    = 2
) (
    input  logic                s_axi_aclk,
    input  logic                s_axi_aresetn,
    gpio_spi_master_if.slave    csr,
    output logic                spiSclk,
    output logic [CS_COUNT-1:0] spiCsn,
    output logic                spiMosi,
    input  logic                spiMiso
);

    localparam int CNT_W  = $clog2(CLK_DIV);
    localparam int HALF_W = $clog2(2 * SHIFT_WIDTH);
    localparam logic [CNT_W-1:0]  DIV_LAST       = CNT_W'(CLK_DIV - 1);
    localparam logic [HALF_W-1:0] HALF_LAST      = HALF_W'(2 * SHIFT_WIDTH - 1);
    localparam logic [HALF_W-1:0] HALF_LAST_FALL = HALF_W'(2 * SHIFT_WIDTH - 2);
    localparam logic [3:0]        CS_LIMIT       = 4'(CS_COUNT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_SHIFT = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    state_t                   state_r, state_nxt_s;
    logic [CNT_W-1:0]         div_cnt_r, div_cnt_nxt_s;
    logic [HALF_W-1:0]        half_cnt_r, half_cnt_nxt_s;
    logic [SHIFT_WIDTH-1:0]   tx_r, tx_nxt_s;
    logic [SHIFT_WIDTH-1:0]   rx_r, rx_nxt_s;
    logic [SHIFT_WIDTH-1:0]   rx_data_r, rx_data_nxt_s;
    logic                     busy_r, busy_nxt_s;
    logic                     overrun_r, overrun_nxt_s;
    logic                     bad_sel_r, bad_sel_nxt_s;
    logic                     sclk_r, sclk_nxt_s;
    logic [CS_COUNT-1:0]      csn_r, csn_nxt_s;
    logic                     div_tc_s;
    logic [2:0]               cs_idx_s;
    logic                     cs_ok_s;
    logic                     unused_s;

    assign cs_idx_s = csr.GPIO_OUT[30:28];
    assign cs_ok_s  = ({1'b0, cs_idx_s} < CS_LIMIT);
    assign div_tc_s = (div_cnt_r == DIV_LAST);
    assign unused_s = ^{csr.GPIO_OUT[31], csr.GPIO_OUT[27:SHIFT_WIDTH]};

    // Next-state and next-output logic for the transfer sequencer.
    always_comb begin
        state_nxt_s    = state_r;
        div_cnt_nxt_s  = div_cnt_r;
        half_cnt_nxt_s = half_cnt_r;
        tx_nxt_s       = tx_r;
        rx_nxt_s       = rx_r;
        rx_data_nxt_s  = rx_data_r;
        busy_nxt_s     = busy_r;
        overrun_nxt_s  = overrun_r;
        bad_sel_nxt_s  = bad_sel_r;
        sclk_nxt_s     = sclk_r;
        csn_nxt_s      = csn_r;

        case (state_r)
            ST_IDLE: begin
                div_cnt_nxt_s  = '0;
                half_cnt_nxt_s = '0;
                if (csr.csrStrobe && cs_ok_s) begin
                    state_nxt_s   = ST_SETUP;
                    tx_nxt_s      = csr.GPIO_OUT[SHIFT_WIDTH-1:0];
                    rx_nxt_s      = '0;
                    busy_nxt_s    = 1'b1;
                    overrun_nxt_s = 1'b0;
                    bad_sel_nxt_s = 1'b0;
                    csn_nxt_s     = ~(CS_COUNT'(1'b1) << cs_idx_s);
                end else if (csr.csrStrobe) begin
                    bad_sel_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (div_tc_s) begin
                    // First SCLK rise; MOSI has been showing the MSB since SETUP began.
                    state_nxt_s   = ST_SHIFT;
                    div_cnt_nxt_s = '0;
                    sclk_nxt_s    = 1'b1;
                    rx_nxt_s      = (rx_r << 1) | SHIFT_WIDTH'(spiMiso);
                end else begin
                    div_cnt_nxt_s = div_cnt_r + 1'b1;
                end
            end
            ST_SHIFT: begin
                if (!div_tc_s) begin
                    div_cnt_nxt_s = div_cnt_r + 1'b1;
                end else if (half_cnt_r == HALF_LAST) begin
                    state_nxt_s    = ST_HOLD;
                    div_cnt_nxt_s  = '0;
                    half_cnt_nxt_s = '0;
                end else if (!half_cnt_r[0]) begin
                    // Falling edge; MOSI is left on the last bit after the final fall.
                    div_cnt_nxt_s  = '0;
                    half_cnt_nxt_s = half_cnt_r + 1'b1;
                    sclk_nxt_s     = 1'b0;
                    if (half_cnt_r != HALF_LAST_FALL) begin
                        tx_nxt_s = tx_r << 1;
                    end else begin
                        tx_nxt_s = tx_r;
                    end
                end else begin
                    div_cnt_nxt_s  = '0;
                    half_cnt_nxt_s = half_cnt_r + 1'b1;
                    sclk_nxt_s     = 1'b1;
                    rx_nxt_s       = (rx_r << 1) | SHIFT_WIDTH'(spiMiso);
                end
            end
            ST_HOLD: begin
                if (div_tc_s) begin
                    state_nxt_s   = ST_IDLE;
                    div_cnt_nxt_s = '0;
                    csn_nxt_s     = '1;
                    rx_data_nxt_s = rx_r;
                    busy_nxt_s    = 1'b0;
                end else begin
                    div_cnt_nxt_s = div_cnt_r + 1'b1;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                csn_nxt_s   = '1;
                sclk_nxt_s  = 1'b0;
                busy_nxt_s  = 1'b0;
            end
        endcase

        if (csr.csrStrobe && (state_r != ST_IDLE)) begin
            overrun_nxt_s = 1'b1;
        end else begin
            overrun_nxt_s = overrun_nxt_s;
        end
    end

    // State and output registers; reset aborts any transfer in flight.
    always_ff @(posedge s_axi_aclk) begin
        if (!s_axi_aresetn) begin
            state_r    <= ST_IDLE;
            div_cnt_r  <= '0;
            half_cnt_r <= '0;
            tx_r       <= '0;
            rx_r       <= '0;
            rx_data_r  <= '0;
            busy_r     <= 1'b0;
            overrun_r  <= 1'b0;
            bad_sel_r  <= 1'b0;
            sclk_r     <= 1'b0;
            csn_r      <= '1;
        end else begin
            state_r    <= state_nxt_s;
            div_cnt_r  <= div_cnt_nxt_s;
            half_cnt_r <= half_cnt_nxt_s;
            tx_r       <= tx_nxt_s;
            rx_r       <= rx_nxt_s;
            rx_data_r  <= rx_data_nxt_s;
            busy_r     <= busy_nxt_s;
            overrun_r  <= overrun_nxt_s;
            bad_sel_r  <= bad_sel_nxt_s;
            sclk_r     <= sclk_nxt_s;
            csn_r      <= csn_nxt_s;
        end
    end

    assign spiSclk    = sclk_r;
    assign spiCsn     = csn_r;
    assign spiMosi    = tx_r[SHIFT_WIDTH-1];
    assign csr.status = {busy_r, overrun_r, bad_sel_r, 5'b00000, 24'(rx_data_r)};

endmodule

// File: tb/tb_gpio_spi_master.sv
// Self-checking bench for gpio_spi_master: directed scenarios plus random
// transfers, judged against a transaction-level model of the status word.
module tb_gpio_spi_master;

    localparam int CLK_DIV_P = 4;
    localparam int SW_P      = 24;
    localparam int CS_N      = 2;
    localparam int XFER_CYC  = (2 * SW_P + 2) * CLK_DIV_P;

    logic            clk;
    logic            rst_n;
    logic            spiSclk;
    logic [CS_N-1:0] spiCsn;
    logic            spiMosi;
    logic            spiMiso;

    gpio_spi_master_if bus ();

    gpio_spi_master #(
        .CLK_DIV    (CLK_DIV_P),
        .SHIFT_WIDTH(SW_P),
        .CS_COUNT   (CS_N)
    ) dut (
        .s_axi_aclk   (clk),
        .s_axi_aresetn(rst_n),
        .csr          (bus),
        .spiSclk      (spiSclk),
        .spiCsn       (spiCsn),
        .spiMosi      (spiMosi),
        .spiMiso      (spiMiso)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    logic [23:0] m_rx;
    logic        m_ovr;
    logic        m_bad;

    function automatic logic [31:0] exp_status();
        return {1'b0, m_ovr, m_bad, 5'b00000, m_rx};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One complete transfer, observed cycle by cycle from the pins.
    task automatic xfer(input logic [31:0] cmd, input logic loopback, input logic [23:0] miso_word,
                        input int ovr_at, input logic [31:0] ovr_cmd, input logic immediate);
        int          cs;
        logic [23:0] tx;
        logic [23:0] exp_rx;
        logic [23:0] cap;
        logic [1:0]  sel_mask;
        logic        prev_sclk;
        int          busy_c, rise_c, multi_low, cyc, bit_idx;
        int          low_c [CS_N];
        cs        = int'(cmd[30:28]);
        tx        = cmd[23:0];
        exp_rx    = loopback ? tx : miso_word;
        sel_mask  = 2'b01 << cs;
        busy_c    = 0;
        rise_c    = 0;
        multi_low = 0;
        cyc       = 0;
        bit_idx   = 23;
        cap       = 24'h000000;
        prev_sclk = 1'b0;
        for (int i = 0; i < CS_N; i++) low_c[i] = 0;
        if (immediate) begin
            check("b2b_busy_low", {31'd0, bus.status[31]}, 32'd0);
            check("b2b_gap_csn", {30'd0, spiCsn}, 32'h3);
        end else begin
            @(negedge clk);
        end
        bus.csrStrobe = 1'b1;
        bus.GPIO_OUT  = cmd;
        @(negedge clk);
        bus.csrStrobe = 1'b0;
        m_ovr = 1'b0;
        m_bad = 1'b0;
        spiMiso = loopback ? spiMosi : miso_word[23];
        while (bus.status[31] === 1'b1 && cyc < 1000) begin
            if (cyc == 0) begin
                check("mosi_msb_setup", {31'd0, spiMosi}, {31'd0, tx[23]});
                check("csn_selected", {30'd0, spiCsn}, {30'd0, ~sel_mask});
            end
            busy_c++;
            for (int i = 0; i < CS_N; i++) if (!spiCsn[i]) low_c[i]++;
            if ($countones(~spiCsn) > 1) multi_low++;
            if (spiSclk && !prev_sclk) begin
                rise_c++;
                cap = {cap[22:0], spiMosi};
            end
            if (!loopback && !spiSclk && prev_sclk) begin
                bit_idx--;
                if (bit_idx >= 0) spiMiso = miso_word[bit_idx];
            end
            if (loopback) spiMiso = spiMosi;
            prev_sclk = spiSclk;
            if (cyc == ovr_at) begin
                bus.csrStrobe = 1'b1;
                bus.GPIO_OUT  = ovr_cmd;
                m_ovr         = 1'b1;
            end else begin
                bus.csrStrobe = 1'b0;
            end
            cyc++;
            @(negedge clk);
        end
        bus.csrStrobe = 1'b0;
        m_rx = exp_rx;
        check("xfer_timeout", {31'd0, (cyc < 1000)}, 32'd1);
        check("busy_cycles", busy_c, XFER_CYC);
        check("csn_sel_low", low_c[cs], XFER_CYC);
        check("csn_other_low", low_c[1 - cs], 0);
        check("csn_multi_low", multi_low, 0);
        check("sclk_rises", rise_c, SW_P);
        check("mosi_stream", {8'd0, cap}, {8'd0, tx});
        check("status_done", bus.status, exp_status());
        check("idle_csn", {30'd0, spiCsn}, 32'h3);
        check("idle_sclk", {31'd0, spiSclk}, 32'd0);
        check("mosi_hold", {31'd0, spiMosi}, {31'd0, tx[0]});
    endtask

    // Command with an out-of-range chip select: nothing may move on the bus.
    task automatic bad_select(input logic [31:0] cmd);
        int act;
        act = 0;
        @(negedge clk);
        bus.csrStrobe = 1'b1;
        bus.GPIO_OUT  = cmd;
        @(negedge clk);
        bus.csrStrobe = 1'b0;
        m_bad = 1'b1;
        repeat (20) begin
            if (spiSclk || bus.status[31] || spiCsn != 2'b11) act++;
            @(negedge clk);
        end
        check("badsel_activity", act, 0);
        check("badsel_status", bus.status, exp_status());
    endtask

    initial begin
        logic [31:0] cmd;
        logic        prev;
        int          rises, cyc;

        rst_n         = 1'b0;
        bus.csrStrobe = 1'b0;
        bus.GPIO_OUT  = 32'h0000_0000;
        spiMiso       = 1'b0;
        m_rx          = 24'h000000;
        m_ovr         = 1'b0;
        m_bad         = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_status", bus.status, 32'h0000_0000);
        check("rst_csn", {30'd0, spiCsn}, 32'h3);
        check("rst_sclk", {31'd0, spiSclk}, 32'd0);
        check("rst_mosi", {31'd0, spiMosi}, 32'd0);

        // Basic loopback transfer, then chip select 1 with MISO tied high.
        xfer(32'h00A5_C3F0, 1'b1, 24'h000000, -1, 32'h0, 1'b0);
        check("basic_status", bus.status, 32'h00A5_C3F0);
        xfer(32'h1000_0001, 1'b0, 24'hFFFFFF, -1, 32'h0, 1'b0);
        check("cs1_status", bus.status, 32'h00FF_FFFF);

        // Overrun, then a back-to-back accepted command that clears it.
        xfer(32'h0000_0011, 1'b0, 24'($urandom), 49, 32'h0000_0022, 1'b0);
        check("overrun_bit", {31'd0, bus.status[30]}, 32'd1);
        cmd = $urandom;
        cmd[30:28] = {2'b00, 1'($urandom_range(0, 1))};
        xfer(cmd, 1'b0, 24'($urandom), -1, 32'h0, 1'b1);
        check("overrun_cleared", {31'd0, bus.status[30]}, 32'd0);

        bad_select(32'h3000_0000);
        cmd = $urandom;
        cmd[30:28] = 3'($urandom_range(2, 7));
        bad_select(cmd);

        // Random transfers, some issued back to back.
        for (int k = 0; k < 5; k++) begin
            cmd = $urandom;
            cmd[30:28] = {2'b00, 1'($urandom_range(0, 1))};
            xfer(cmd, 1'($urandom_range(0, 1)), 24'($urandom), -1, 32'h0, 1'($urandom_range(0, 1)));
        end

        // Reset while shifting, at the tenth SCLK rise.
        cmd = $urandom;
        cmd[30:28] = 3'b000;
        @(negedge clk);
        bus.csrStrobe = 1'b1;
        bus.GPIO_OUT  = cmd;
        @(negedge clk);
        bus.csrStrobe = 1'b0;
        prev  = 1'b0;
        rises = 0;
        cyc   = 0;
        while (1'b1) begin
            if (spiSclk && !prev) rises++;
            prev = spiSclk;
            if (rises == 10 || cyc >= 1000) break;
            cyc++;
            @(negedge clk);
        end
        check("rst_mid_reach", rises, 10);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_rx  = 24'h000000;
        m_ovr = 1'b0;
        m_bad = 1'b0;
        check("rst_mid_csn", {30'd0, spiCsn}, 32'h3);
        check("rst_mid_sclk", {31'd0, spiSclk}, 32'd0);
        check("rst_mid_status", bus.status, exp_status());
        check("rst_mid_mosi", {31'd0, spiMosi}, 32'd0);
        cmd = $urandom;
        cmd[30:28] = {2'b00, 1'($urandom_range(0, 1))};
        xfer(cmd, 1'b0, 24'($urandom), -1, 32'h0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
